// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S fetch/decode datapath.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_BRANCH = 4'd1,
    I_BZERO  = 4'd2,
    I_BNEG   = 4'd3,
    I_BNZERO = 4'd4,
    I_BNNEG  = 4'd5,
    I_LOAD   = 4'd6,
    I_STORE  = 4'd7,
    I_MOVE   = 4'd8,
    I_ADD    = 4'd9,
    I_SUB    = 4'd10,
    I_AND    = 4'd11,
    I_OR     = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;

  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_BRANCH = 5'b00001;
  localparam logic [4:0] OP_BZERO  = 5'b00010;
  localparam logic [4:0] OP_BNEG   = 5'b00011;
  localparam logic [4:0] OP_BNZERO = 5'b01010;
  localparam logic [4:0] OP_BNNEG  = 5'b01011;
  localparam logic [4:0] OP_LOAD   = 5'b10000;
  localparam logic [4:0] OP_STORE  = 5'b10001;
  localparam logic [4:0] OP_MOVE   = 5'b10010;
  localparam logic [4:0] OP_ADD    = 5'b10100;
  localparam logic [4:0] OP_SUB    = 5'b10101;
  localparam logic [4:0] OP_AND    = 5'b10110;
  localparam logic [4:0] OP_OR     = 5'b10111;
  localparam logic [4:0] OP_HALT   = 5'b11111;

  // IR layout; the memory address is always the low byte (c/a/b overlay it).
  typedef struct packed {
    logic [4:0] opcode;    // [15:11]
    logic       rsvd10;    // [10]
    logic [1:0] ls_reg;    // [9:8]  LOAD/STORE register
    logic [1:0] rsvd7_6;   // [7:6]
    logic [1:0] c_reg;     // [5:4]
    logic [1:0] a_reg;     // [3:2]
    logic [1:0] b_reg;     // [1:0]
  } ks_ir_fields_t;

  // True for any opcode in the instruction set.
  function automatic logic op_is_defined(input logic [4:0] op);
    logic ok;
    case (op)
      OP_NOP, OP_BRANCH, OP_BZERO, OP_BNEG, OP_BNZERO, OP_BNNEG,
      OP_LOAD, OP_STORE, OP_MOVE, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_HALT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ks_instr_decoder.sv
// Combinational IR decoder: instruction type, operand indices, illegal flag.
module ks_instr_decoder
  import k_and_s_pkg::*;
(
  input  logic [15:0]             ir_i,
  output decoded_instruction_type decoded_instruction_o,
  output logic [1:0]              a_addr_o,
  output logic [1:0]              b_addr_o,
  output logic [1:0]              c_addr_o,
  output logic                    illegal_o
);

  ks_ir_fields_t f;
  assign f = ks_ir_fields_t'(ir_i);

  // Map opcode to instruction type and route only the operand fields it uses.
  always_comb begin
    decoded_instruction_o = I_NOP;
    a_addr_o              = 2'b00;
    b_addr_o              = 2'b00;
    c_addr_o              = 2'b00;
    illegal_o             = 1'b0;
    case (f.opcode)
      OP_NOP:    decoded_instruction_o = I_NOP;
      OP_BRANCH: decoded_instruction_o = I_BRANCH;
      OP_BZERO:  decoded_instruction_o = I_BZERO;
      OP_BNEG:   decoded_instruction_o = I_BNEG;
      OP_BNZERO: decoded_instruction_o = I_BNZERO;
      OP_BNNEG:  decoded_instruction_o = I_BNNEG;
      OP_HALT:   decoded_instruction_o = I_HALT;
      OP_LOAD: begin
        decoded_instruction_o = I_LOAD;
        c_addr_o              = f.ls_reg;
      end
      OP_STORE: begin
        decoded_instruction_o = I_STORE;
        a_addr_o              = f.ls_reg;
      end
      OP_MOVE: begin
        decoded_instruction_o = I_MOVE;
        c_addr_o              = f.c_reg;
        a_addr_o              = f.a_reg;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        case (f.opcode)
          OP_ADD:  decoded_instruction_o = I_ADD;
          OP_SUB:  decoded_instruction_o = I_SUB;
          OP_AND:  decoded_instruction_o = I_AND;
          default: decoded_instruction_o = I_OR;
        endcase
        c_addr_o = f.c_reg;
        a_addr_o = f.a_reg;
        b_addr_o = f.b_reg;
      end
      default: begin
        decoded_instruction_o = I_NOP;
        illegal_o             = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ks_fetch_decode.sv
// K&S fetch/decode stage: PC, IR, flags, sticky illegal flag and RAM address mux.
module ks_fetch_decode
  import k_and_s_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             ram_rdata,
  input  logic                    ir_enable,
  input  logic                    pc_enable,
  input  logic                    branch,
  input  logic                    addr_sel,
  input  logic                    flags_reg_enable,
  input  logic                    alu_zero,
  input  logic                    alu_neg,
  input  logic                    alu_uovf,
  input  logic                    alu_sovf,
  output logic [7:0]              ram_addr,
  output logic [7:0]              pc,
  output decoded_instruction_type decoded_instruction,
  output logic [1:0]              a_addr,
  output logic [1:0]              b_addr,
  output logic [1:0]              c_addr,
  output logic [7:0]              mem_addr,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow
  ,output logic                   illegal_instr
);

  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;   // {zero, neg, uovf, sovf}
  logic        illegal_q, illegal_d;
  logic        dec_illegal_s;

  ks_instr_decoder u_dec (
    .ir_i                  (ir_q),
    .decoded_instruction_o (decoded_instruction),
    .a_addr_o              (a_addr),
    .b_addr_o              (b_addr),
    .c_addr_o              (c_addr),
    .illegal_o             (dec_illegal_s)
  );

  assign mem_addr          = ir_q[7:0];
  assign pc                = pc_q;
  assign ram_addr          = addr_sel ? pc_q : ir_q[7:0];
  assign zero_op           = flags_q[3];
  assign neg_op            = flags_q[2];
  assign unsigned_overflow = flags_q[1];
  assign signed_overflow   = flags_q[0];
  assign illegal_instr     = illegal_q;

  // Next-state: branch target uses the old IR; illegal is judged on the word
  // being latched so the sticky flag rises together with the IR update.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    if (pc_enable) begin
      if (branch) pc_d = ir_q[7:0];
      else        pc_d = pc_q + 8'd1;
    end else begin
      pc_d = pc_q;
    end
    if (ir_enable) begin
      ir_d      = ram_rdata;
      illegal_d = illegal_q | ~op_is_defined(ram_rdata[15:11]);
    end else begin
      ir_d      = ir_q;
      illegal_d = illegal_q;
    end
    if (flags_reg_enable) flags_d = {alu_zero, alu_neg, alu_uovf, alu_sovf};
    else                  flags_d = flags_q;
  end

  // State registers with synchronous reset taking priority over all enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  // Decoder's own illegal view is informational; the sticky flag is the output.
  logic unused_s;
  assign unused_s = dec_illegal_s;

endmodule

// File: tb/tb_ks_fetch_decode.sv
// Scoreboard bench for ks_fetch_decode: stimulus pushes expectations, monitor checks.
module tb_ks_fetch_decode;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, ir_enable = 1'b0, pc_enable = 1'b0, branch = 1'b0;
  logic        addr_sel = 1'b0, flags_reg_enable = 1'b0;
  logic        alu_zero = 1'b0, alu_neg = 1'b0, alu_uovf = 1'b0, alu_sovf = 1'b0;
  logic [15:0] ram_rdata;
  logic [7:0]  ram_addr, pc, mem_addr;
  decoded_instruction_type decoded_instruction;
  logic [1:0]  a_addr, b_addr, c_addr;
  logic        zero_op, neg_op, unsigned_overflow, signed_overflow, illegal_instr;

  logic [15:0] mem [256];
  assign ram_rdata = mem[ram_addr];

  ks_fetch_decode #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .ram_rdata(ram_rdata), .ir_enable(ir_enable),
    .pc_enable(pc_enable), .branch(branch), .addr_sel(addr_sel),
    .flags_reg_enable(flags_reg_enable), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_uovf(alu_uovf), .alu_sovf(alu_sovf), .ram_addr(ram_addr), .pc(pc),
    .decoded_instruction(decoded_instruction), .a_addr(a_addr), .b_addr(b_addr),
    .c_addr(c_addr), .mem_addr(mem_addr), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .illegal_instr(illegal_instr)
  );

  typedef struct {
    logic [7:0] pc, ram_addr, mem_addr;
    logic [3:0] dec;
    logic [1:0] a, b, c;
    logic [3:0] flags;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural state of the reference machine.
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [3:0]  m_flags;
  logic        m_ill;

  // Instruction set table straight from the ISA listing.
  function automatic void isa(input logic [15:0] w, output logic [3:0] dec,
                              output logic [1:0] a, b, c, output logic legal);
    logic [4:0] op;
    op = w[15:11];
    a = 2'd0; b = 2'd0; c = 2'd0; legal = 1'b1; dec = I_NOP;
    case (op)
      5'd0:  dec = I_NOP;
      5'd1:  dec = I_BRANCH;
      5'd2:  dec = I_BZERO;
      5'd3:  dec = I_BNEG;
      5'd10: dec = I_BNZERO;
      5'd11: dec = I_BNNEG;
      5'd31: dec = I_HALT;
      5'd16: begin dec = I_LOAD;  c = w[9:8]; end
      5'd17: begin dec = I_STORE; a = w[9:8]; end
      5'd18: begin dec = I_MOVE;  c = w[5:4]; a = w[3:2]; end
      5'd20, 5'd21, 5'd22, 5'd23: begin
        dec = (op == 5'd20) ? I_ADD : (op == 5'd21) ? I_SUB : (op == 5'd22) ? I_AND : I_OR;
        c = w[5:4]; a = w[3:2]; b = w[1:0];
      end
      default: begin dec = I_NOP; legal = 1'b0; end
    endcase
  endfunction

  task automatic step(input logic r, ie, pe, br, asel, fe, z, n, u, s);
    exp_t e;
    logic [15:0] rd;
    logic [3:0]  d;
    logic [1:0]  a, b, c;
    logic        lg;
    @(negedge clk);
    rst = r; ir_enable = ie; pc_enable = pe; branch = br; addr_sel = asel;
    flags_reg_enable = fe; alu_zero = z; alu_neg = n; alu_uovf = u; alu_sovf = s;
    if (r) begin
      m_pc = 8'h00; m_ir = 16'h0000; m_flags = 4'h0; m_ill = 1'b0;
    end else begin
      rd = mem[asel ? m_pc : m_ir[7:0]];
      if (pe) m_pc = br ? m_ir[7:0] : 8'((int'(m_pc) + 1) % 256);
      if (ie) begin
        m_ir = rd;
        isa(rd, d, a, b, c, lg);
        if (!lg) m_ill = 1'b1;
      end
      if (fe) m_flags = {z, n, u, s};
    end
    isa(m_ir, d, a, b, c, lg);
    e.pc = m_pc; e.ram_addr = asel ? m_pc : m_ir[7:0]; e.mem_addr = m_ir[7:0];
    e.dec = d; e.a = a; e.b = b; e.c = c; e.flags = m_flags; e.ill = m_ill;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after each edge, compare DUT outputs with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", {8'h00, pc}, {8'h00, e.pc});
      chk("ram_addr", {8'h00, ram_addr}, {8'h00, e.ram_addr});
      chk("mem_addr", {8'h00, mem_addr}, {8'h00, e.mem_addr});
      chk("decoded", {12'h000, 4'(decoded_instruction)}, {12'h000, e.dec});
      chk("a_addr", {14'h0, a_addr}, {14'h0, e.a});
      chk("b_addr", {14'h0, b_addr}, {14'h0, e.b});
      chk("c_addr", {14'h0, c_addr}, {14'h0, e.c});
      chk("flags", {12'h000, zero_op, neg_op, unsigned_overflow, signed_overflow},
          {12'h000, e.flags});
      chk("illegal", {15'h0, illegal_instr}, {15'h0, e.ill});
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h00] = 16'hA01B;   // ADD c=1 a=2 b=3
    mem[8'h01] = 16'h083C;   // BRANCH 3C
    mem[8'h3C] = 16'h08FF;   // BRANCH FF
    mem[8'hFF] = 16'h8280;   // LOAD r2, 80
    mem[8'h80] = 16'h3000;   // undefined opcode 00110
    m_pc = 8'h00; m_ir = 16'h0000; m_flags = 4'h0; m_ill = 1'b0;

    // Reset with every enable high.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Fetch ADD.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Fetch BRANCH 3C, then take it.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Fetch BRANCH FF, take it, then increment FF -> 00.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Branch without pc_enable has no effect.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Data-side fetch of LOAD r2,80 from mem[FF]; then address mux shows 80.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Flags latch then hold.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    // Illegal word from mem[80], then a legal fetch; sticky until reset.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Simultaneous fetch and branch: target from old IR.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_fetch_decode.md
# ks_fetch_decode

Upstream neighbour of `control_unit` in the K&S processor. Holds the program counter, instruction register and flags register, and decodes the latched instruction into `decoded_instruction_type` and operand fields. Drives the RAM address mux. Sequences PC/IR/flag updates from the enables issued by `control_unit`, and returns the registered flags that the control unit uses for conditional branches.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ram_rdata`  in  16  RAM read data; combinational read of `ram_addr`
- `ir_enable`  in  1  latch `ram_rdata` into IR
- `pc_enable`  in  1  update PC
- `branch`  in  1  with `pc_enable`: PC takes `mem_addr` instead of PC+1
- `addr_sel`  in  1  1: `ram_addr`=PC; 0: `ram_addr`=`mem_addr`
- `flags_reg_enable`  in  1  latch ALU flags
- `alu_zero`, `alu_neg`, `alu_uovf`, `alu_sovf`  in  1 each  raw ALU flags
- `ram_addr`  out  8  RAM address (combinational mux)
- `pc`  out  8  current PC
- `decoded_instruction`  out  `decoded_instruction_type`  decode of IR
- `a_addr`, `b_addr`, `c_addr`  out  2 each  register-file operand indices
- `mem_addr`  out  8  IR[7:0]
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow`  out  1 each  registered flags
- `illegal_instr`  out  1  sticky: an undefined opcode was latched

## Operation
- Opcode = IR[15:11]. Encoding: NOP 00000, BRANCH 00001, BZERO 00010, BNEG 00011, BNZERO 01010, BNNEG 01011, LOAD 10000, STORE 10001, MOVE 10010, ADD 10100, SUB 10101, AND 10110, OR 10111, HALT 11111.
- Fields:
  - LOAD/STORE register = IR[9:8]. LOAD drives `c_addr`. STORE drives `a_addr`.
  - ALU: `c_addr`=IR[5:4], `a_addr`=IR[3:2], `b_addr`=IR[1:0].
  - MOVE: `c_addr`=IR[5:4], `a_addr`=IR[3:2].
  - Unused address outputs are 2'b00.
  - `mem_addr`=IR[7:0] for every opcode.
- Undefined opcode: decodes as I_NOP and sets `illegal_instr` on the cycle after it is latched into IR. The flag stays set until `rst`.
- PC update, on `pc_enable`:
  - `branch`=0: PC ← PC+1, modulo 256 (8'hFF → 8'h00).
  - `branch`=1: PC ← `mem_addr` of the current IR.
  - `branch` without `pc_enable` has no effect.
- IR update: on `ir_enable`, IR ← `ram_rdata`.
- Flags update: on `flags_reg_enable`, all four flags latch together. Otherwise they hold.
- Simultaneous events:
  - `ir_enable` with `pc_enable`+`branch`: branch target comes from the old IR, and IR loads the new word. Both updates take effect.
  - `rst` together with any enable: `rst` wins.
- Decode outputs are combinational from IR. There is no internal FSM; sequencing belongs to `control_unit`.

## Timing
- Reset values (cycle after `rst` sampled high):
  - PC=`RESET_PC`.
  - IR=16'h0000, so `decoded_instruction`=I_NOP, all field outputs 0, `mem_addr`=0.
  - All flags 0. `illegal_instr`=0.
  - `ram_addr`=`RESET_PC` when `addr_sel`=1.
- Fetch latency: with `addr_sel`=1 and `ir_enable`=1 at edge N, `decoded_instruction` reflects mem[PC] in cycle N+1.
- PC, IR, flags and `illegal_instr` all change exactly one edge after their enable is sampled.
- `ram_addr` has zero latency: it follows `addr_sel`, PC and IR combinationally.
- Reset mid-instruction: state is lost and the next fetch is from `RESET_PC`.

## Structure
- `k_and_s_pkg` holds:
  - `decoded_instruction_type` (existing).
  - 5-bit opcode localparams `OP_*`.
  - A `ks_ir_fields_t` packed struct for IR field slicing.
- One sub-module, `ks_instr_decoder`: purely combinational, IR → `decoded_instruction`, operand addresses, `illegal`. Registers (PC, IR, flags, sticky) stay in the top.

## Test plan
- Reset: assert `rst` with all enables high → PC=00, IR=0000, I_NOP, flags 0, `illegal_instr`=0.
- Fetch: mem[00]=16'hA01B, pulse `ir_enable`+`pc_enable` with `addr_sel`=1 → PC=01, I_ADD, `c_addr`=1, `a_addr`=2, `b_addr`=3.
- Branch: IR holds BRANCH with IR[7:0]=8'h3C, pulse `pc_enable`+`branch` → PC=3C. Repeat with `branch`=0 from PC=FF → PC=00.
- Address mux: IR=LOAD, IR[9:8]=2, IR[7:0]=8'h80, `addr_sel`=0 → `ram_addr`=80, `c_addr`=2.
- Flags: drive `alu_zero`=1, `alu_sovf`=1 with `flags_reg_enable`=1 for one cycle, then drive all ALU flags to 0 → registered flags stay 1,0,0,1.
- Illegal: latch 16'h3000 (opcode 00110) → I_NOP, `illegal_instr`=1 and stays 1 after a legal fetch. `rst` clears it.
